// File: rtl/hdmi_timing_ctrl.sv
// Video raster sequencer: hsync/vsync/de and pixel coordinates advanced on pix_ce.
// Timing updates are shadowed in a pending slot and swapped in only at a frame boundary.
module hdmi_timing_ctrl #(
  parameter int unsigned   CW        = 12,
  parameter logic          HSYNC_POL = 1'b0,
  parameter logic          VSYNC_POL = 1'b0,
  parameter logic [CW-1:0] DEF_HA    = 640,
  parameter logic [CW-1:0] DEF_HSS   = 656,
  parameter logic [CW-1:0] DEF_HSE   = 752,
  parameter logic [CW-1:0] DEF_HT    = 800,
  parameter logic [CW-1:0] DEF_VA    = 480,
  parameter logic [CW-1:0] DEF_VSS   = 490,
  parameter logic [CW-1:0] DEF_VSE   = 492,
  parameter logic [CW-1:0] DEF_VT    = 525
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            pix_ce,
  input  logic            enable,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [4*CW-1:0] cfg_h,
  input  logic [4*CW-1:0] cfg_v,
  output logic            cfg_err,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [CW-1:0]   x,
  output logic [CW-1:0]   y,
  output logic            frame_start,
  output logic            running
);

  // Field order matches the cfg bus: {total, sync_end, sync_start, active}
  typedef struct packed {
    logic [CW-1:0] t;
    logic [CW-1:0] se;
    logic [CW-1:0] ss;
    logic [CW-1:0] a;
  } axis_t;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0] ONE   = 1;
  localparam logic [CW-1:0] ZERO  = '0;
  localparam axis_t         DEF_H = '{t: DEF_HT, se: DEF_HSE, ss: DEF_HSS, a: DEF_HA};
  localparam axis_t         DEF_V = '{t: DEF_VT, se: DEF_VSE, ss: DEF_VSS, a: DEF_VA};

  state_t        state_q, state_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  axis_t         act_h, act_v, pend_h, pend_v, use_h, use_v;
  axis_t         in_h, in_v;
  logic          pend_full;
  logic          accept, cfg_ok, apply, start;
  logic          run_d, de_d, hs_on, vs_on;

  function automatic logic axis_ok(input axis_t c);
    return (c.a != ZERO) && (c.a <= c.ss) && (c.ss < c.se) && (c.se <= c.t);
  endfunction

  assign in_h      = axis_t'(cfg_h);
  assign in_v      = axis_t'(cfg_v);
  assign cfg_ready = ~pend_full;
  assign accept    = cfg_valid & cfg_ready;
  assign cfg_ok    = axis_ok(in_h) & axis_ok(in_v);
  assign running   = (state_q == RUN);
  assign x         = h_q;
  assign y         = v_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    apply   = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pix_ce && enable) begin
          state_d = RUN;
          h_d     = ZERO;
          v_d     = ZERO;
          apply   = pend_full;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (pix_ce) begin
          if (h_q < act_h.t - ONE) begin
            h_d = h_q + ONE;
          end else begin
            h_d = ZERO;
            if (v_q < act_v.t - ONE) begin
              v_d = v_q + ONE;
            end else begin
              v_d   = ZERO;
              apply = pend_full;
              if (enable) start   = 1'b1;
              else        state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs describe the new (h,v), so they must use the timing in force after a swap
    use_h = apply ? pend_h : act_h;
    use_v = apply ? pend_v : act_v;
    run_d = (state_d == RUN);
    de_d  = run_d && (h_d < use_h.a) && (v_d < use_v.a);
    hs_on = run_d && (h_d >= use_h.ss) && (h_d < use_h.se);
    vs_on = run_d && (v_d >= use_v.ss) && (v_d < use_v.se);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_q         <= ZERO;
      v_q         <= ZERO;
      act_h       <= DEF_H;
      act_v       <= DEF_V;
      pend_h      <= '0;
      pend_v      <= '0;
      pend_full   <= 1'b0;
      cfg_err     <= 1'b0;
      de          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      frame_start <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      cfg_err     <= accept & ~cfg_ok;
      de          <= de_d;
      hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      frame_start <= start;
      if (apply) begin
        act_h     <= pend_h;
        act_v     <= pend_v;
        pend_full <= 1'b0;
      end
      // accept needs an empty slot and apply needs a full one, so these never collide
      if (accept && cfg_ok) begin
        pend_h    <= in_h;
        pend_v    <= in_v;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Directed bench for hdmi_timing_ctrl: default line timing, config swap, rejects, stop, reset.
module tb_hdmi_timing_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        pix_ce = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [47:0] cfg_h = '0;
  logic [47:0] cfg_v = '0;
  logic        cfg_err, hsync, vsync, de, frame_start, running;
  logic [11:0] x, y;

  int n_chk = 0;
  int n_pass = 0;

  hdmi_timing_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pix_ce(pix_ce), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_h(cfg_h), .cfg_v(cfg_v),
    .cfg_err(cfg_err), .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .running(running)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ce_step4();
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    repeat (3) tick();
  endtask

  // Walks one full frame from (0,0) with pix_ce held high, comparing every pixel.
  task automatic check_frame(input string tag, input int ha, input int hss, input int hse,
                             input int ht, input int va, input int vss, input int vse,
                             input int vt);
    logic [31:0] got, exp;
    logic [11:0] ex, ey;
    for (int yy = 0; yy < vt; yy++) begin
      for (int xx = 0; xx < ht; xx++) begin
        ex  = 12'(xx);
        ey  = 12'(yy);
        got = {4'h0, x, y, de, hsync, vsync, frame_start};
        exp = {4'h0, ex, ey, (xx < ha) && (yy < va), !((xx >= hss) && (xx < hse)),
               !((yy >= vss) && (yy < vse)), (xx == 0) && (yy == 0)};
        chk(tag, got, exp);
        tick();
      end
    end
    chk({tag, "_wrap"}, {frame_start, running, 6'h0, x, y}, {2'b11, 6'h0, 24'h0});
  endtask

  task automatic wait_frame(input string tag, input int exp_ticks);
    int n = 0;
    int rdy_bad = 0;
    while (!frame_start && n < 200) begin
      if (cfg_ready) rdy_bad++;
      tick();
      n++;
    end
    chk({tag, "_ticks"}, n, exp_ticks);
    chk({tag, "_rdy_low"}, rdy_bad, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int de_cnt, hs_cnt, hs_first, hs_last, xbad, n;

    // Reset values
    repeat (3) tick();
    chk("rst_outs", {cfg_ready, cfg_err, de, hsync, vsync, frame_start, running},
        7'b1001100);
    chk("rst_xy", {x, y}, 24'h0);
    sys_rst = 1'b0;
    tick();

    // Default 640x480 timing, pix_ce every 4th cycle, one full line
    enable = 1'b1;
    pix_ce = 1'b1;
    tick();
    chk("t1_start", {frame_start, running, de, hsync}, 4'b1111);
    pix_ce = 1'b0;
    tick();
    chk("t1_fs_pulse", {frame_start, x}, 13'h0);
    repeat (2) tick();
    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; xbad = 0;
    for (int i = 0; i < 800; i++) begin
      if (de) de_cnt++;
      if (!hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(x);
        hs_last = int'(x);
      end
      if (int'(x) != i || y != 12'd0) xbad++;
      ce_step4();
    end
    chk("t1_de_cnt", de_cnt, 640);
    chk("t1_hs_cnt", hs_cnt, 96);
    chk("t1_hs_first", hs_first, 656);
    chk("t1_hs_last", hs_last, 751);
    chk("t1_x_seq", xbad, 0);
    chk("t1_next_line", {x, y, vsync}, {12'd0, 12'd1, 1'b1});

    sys_rst = 1'b1;
    enable  = 1'b0;
    tick();
    sys_rst = 1'b0;
    tick();

    // Config accepted in IDLE, then a 10x6 raster
    cfg_h = {12'd10, 12'd8, 12'd6, 12'd4};
    cfg_v = {12'd6, 12'd5, 12'd4, 12'd3};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("t2_pending", {cfg_ready, cfg_err, running}, 3'b000);
    enable = 1'b1;
    pix_ce = 1'b1;
    tick();
    chk("t2_ready_back", cfg_ready, 1'b1);
    check_frame("t2_px", 4, 6, 8, 10, 3, 4, 5, 6);

    // Mid-frame config: old timing finishes the frame, second offer ignored
    cfg_h = {12'd12, 12'd9, 12'd7, 12'd5};
    cfg_v = {12'd5, 12'd4, 12'd3, 12'd2};
    cfg_valid = 1'b1;
    tick();
    chk("t3_pending", {cfg_ready, cfg_err}, 2'b00);
    cfg_h = {12'd10, 12'd6, 12'd6, 12'd4};
    tick();
    cfg_valid = 1'b0;
    chk("t3_ignored", {cfg_err, x, y}, {1'b0, 12'd2, 12'd0});
    wait_frame("t3", 58);
    chk("t3_applied", cfg_ready, 1'b1);
    check_frame("t3_px", 5, 7, 9, 12, 2, 3, 4, 5);

    // Invalid config rejected with a single error pulse
    cfg_h = {12'd10, 12'd6, 12'd6, 12'd4};
    cfg_v = {12'd6, 12'd5, 12'd4, 12'd3};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("t4_err_pulse", {cfg_err, cfg_ready}, 2'b11);
    tick();
    chk("t4_err_clear", {cfg_err, cfg_ready}, 2'b01);
    n = 0;
    while (!frame_start && n < 200) begin
      tick();
      n++;
    end
    chk("t4_ticks", n, 58);
    check_frame("t4_px", 5, 7, 9, 12, 2, 3, 4, 5);

    // Drop enable at (2,1): frame completes, then idle
    repeat (14) tick();
    chk("t5_pos", {x, y}, {12'd2, 12'd1});
    enable = 1'b0;
    n = 0;
    while (running && n < 200) begin
      tick();
      n++;
    end
    chk("t5_ticks", n, 46);
    chk("t5_idle", {de, hsync, vsync, frame_start, x, y}, {4'b0110, 24'h0});
    repeat (3) tick();
    chk("t5_stay", {running, de, x}, 14'h0);

    // Reset mid-line with a pending config
    enable = 1'b1;
    tick();
    chk("t6_start", {frame_start, running}, 2'b11);
    cfg_h = {12'd10, 12'd8, 12'd6, 12'd4};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("t6_pending", cfg_ready, 1'b0);
    repeat (3) tick();
    sys_rst = 1'b1;
    #1;
    chk("t6_async", {cfg_ready, cfg_err, de, hsync, vsync, frame_start, running},
        7'b1001100);
    chk("t6_xy", {x, y}, 24'h0);
    tick();
    sys_rst = 1'b0;
    tick();
    chk("t6_restart", {frame_start, de, x}, {2'b11, 12'd0});
    repeat (639) tick();
    chk("t6_x639", {x, y, de}, {12'd639, 12'd0, 1'b1});
    tick();
    chk("t6_x640", {x, de, hsync}, {12'd640, 1'b0, 1'b1});
    repeat (16) tick();
    chk("t6_x656", {x, hsync}, {12'd656, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
